// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: PC sequencing, imem req/ack handshake, prefetch queue to decode.
// Fetched word reaches decode one cycle after its ack; full queue, halt or redirect deasserts imem_req.
module ifetch_ctrl #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] HALT_INST = 16'hEFFF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req,
  output logic [15:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [15:0]              imem_rdata,
  output logic                     inst_valid,
  output logic [15:0]              inst_data,
  output logic [15:0]              inst_pc,
  input  logic                     inst_ready,
  input  logic                     redirect_valid,
  input  logic [15:0]              redirect_pc,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] data;
  } entry_t;

  entry_t          queue [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic [15:0]     fetch_pc;

  logic            full;
  logic            fire;
  logic            deq;
  logic            halt_hit;

  // Reset gates the request combinationally so an in-flight fetch is abandoned at once.
  always_comb begin
    full      = (count == FULL_COUNT);
    imem_req  = rst_n && !halted && !redirect_valid && !full;
    imem_addr = fetch_pc;
    fire      = imem_req && imem_ack;
    halt_hit  = fire && (imem_rdata == HALT_INST);
  end

  // A redirect discards the dequeue of its own cycle along with the rest of the queue.
  always_comb begin
    inst_valid = (count != '0);
    inst_data  = queue[rptr].data;
    inst_pc    = queue[rptr].pc;
    deq        = inst_valid && inst_ready && !redirect_valid;
    fifo_count = count;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        queue[i] <= '0;
      end
    end else if (fire) begin
      queue[wptr] <= '{pc: fetch_pc, data: imem_rdata};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      fetch_pc <= RESET_PC;
      halted   <= 1'b0;
    end else if (redirect_valid) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      fetch_pc <= redirect_pc & 16'hFFFE;
      halted   <= 1'b0;
    end else begin
      if (fire) begin
        wptr     <= wptr + AW'(1);
        fetch_pc <= fetch_pc + 16'd2;
      end
      if (deq) begin
        rptr <= rptr + AW'(1);
      end
      unique case ({fire, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (halt_hit) begin
        halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Randomised and directed bench for ifetch_ctrl against a queue-based fetch model.
module tb_ifetch_ctrl;

  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] HALT     = 16'hEFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata;
  logic        inst_valid;
  logic [15:0] inst_data;
  logic [15:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halted;
  logic [2:0]  fifo_count;

  ifetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .HALT_INST(HALT)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:32767];
  assign imem_rdata = mem[imem_addr[15:1]];

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] data;
  } ent_t;

  // Reference model: program-order queue of fetched (pc, word) pairs.
  ent_t        q[$];
  logic [15:0] m_pc;
  bit          m_halted;
  bit          exp_req;
  bit          exp_valid;
  ent_t        exp_head;
  int          checks = 0;
  int          errors = 0;

  task automatic model_reset();
    q.delete();
    m_pc     = RESET_PC;
    m_halted = 0;
  endtask

  task automatic drive(input bit a, input bit r, input bit rv, input logic [15:0] rpc);
    imem_ack       = a;
    inst_ready     = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    exp_req   = !m_halted && !rv && (q.size() < DEPTH);
    exp_valid = (q.size() != 0);
    exp_head  = exp_valid ? q[0] : '0;
  endtask

  task automatic tick();
    logic [15:0] w;
    bit fire;
    fire = exp_req && imem_ack;
    if (redirect_valid) begin
      q.delete();
      m_pc     = redirect_pc & 16'hFFFE;
      m_halted = 0;
    end else begin
      if (exp_valid && inst_ready) void'(q.pop_front());
      if (fire) begin
        w = mem[m_pc[15:1]];
        q.push_back('{pc: m_pc, data: w});
        if (w == HALT) m_halted = 1;
        m_pc = m_pc + 16'd2;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    imem_ack = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", inst_valid); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
    checks++; if (inst_data !== 16'h0 || inst_pc !== 16'h0) begin errors++; $display("FAIL reset_head got %h/%h exp 0/0", inst_data, inst_pc); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_straight_line();
    logic [15:0] words [3];
    words[0] = 16'h012F; words[1] = 16'h012E; words[2] = 16'h034C;
    do_reset();
    drive(1, 1, 0, 0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL sl_first_req got %b/%h exp 1/0000", imem_req, imem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL sl_no_bypass got %b exp 0", inst_valid); end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0);
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 16'(2 * i) || inst_data !== words[i]) begin
        errors++; $display("FAIL sl_head%0d got %b/%h/%h exp 1/%h/%h", i, inst_valid, inst_pc, inst_data, 16'(2 * i), words[i]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int fires = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 0);
      if (imem_req && imem_ack) fires++;
      tick();
    end
    drive(1, 0, 0, 0);
    checks++; if (fires != DEPTH) begin errors++; $display("FAIL bp_fetches got %0d exp %0d", fires, DEPTH); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_full got %b exp 0", imem_req); end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL bp_count got %0d exp 4", fifo_count); end
    drive(1, 1, 0, 0);
    checks++; if (imem_req !== 1'b0 || inst_pc !== 16'h0000) begin errors++; $display("FAIL bp_first_deq got %b/%h exp 0/0000", imem_req, inst_pc); end
    tick();
    drive(1, 1, 0, 0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0008) begin errors++; $display("FAIL bp_resume got %b/%h exp 1/0008", imem_req, imem_addr); end
    checks++; if (inst_pc !== 16'h0002) begin errors++; $display("FAIL bp_order1 got %h exp 0002", inst_pc); end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0);
      checks++; if (inst_pc !== 16'(4 + 2 * i)) begin errors++; $display("FAIL bp_order got %h exp %h", inst_pc, 16'(4 + 2 * i)); end
      tick();
    end
  endtask

  task automatic test_wait_state();
    bit          prev_wait = 0;
    logic [15:0] prev_addr = '0;
    bit          a;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      a = (i % 3 == 2);
      drive(a, 1'($urandom_range(0, 1)), 0, 0);
      if (prev_wait && imem_req) begin
        checks++; if (imem_addr !== prev_addr) begin errors++; $display("FAIL ws_addr_hold got %h exp %h", imem_addr, prev_addr); end
      end
      checks++; if (imem_req !== exp_req || (exp_req && imem_addr !== m_pc)) begin errors++; $display("FAIL ws_req got %b/%h exp %b/%h", imem_req, imem_addr, exp_req, m_pc); end
      checks++; if (inst_valid !== exp_valid || (exp_valid && {inst_pc, inst_data} !== exp_head)) begin errors++; $display("FAIL ws_head got %b/%h/%h exp %b/%h", inst_valid, inst_pc, inst_data, exp_valid, exp_head); end
      prev_wait = imem_req && !a;
      prev_addr = imem_addr;
      tick();
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 0, 0);
      tick();
    end
    drive(1, 1, 1, 16'h0025);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rd_req_in_redirect got %b exp 0", imem_req); end
    tick();
    drive(1, 1, 0, 0);
    checks++; if (inst_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL rd_flush got %b/%0d exp 0/0", inst_valid, fifo_count); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0024) begin errors++; $display("FAIL rd_addr got %b/%h exp 1/0024", imem_req, imem_addr); end
    tick();
    drive(1, 1, 0, 0);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'h0024 || inst_data !== mem[16'h0012]) begin errors++; $display("FAIL rd_head got %b/%h/%h exp 1/0024/%h", inst_valid, inst_pc, inst_data, mem[16'h0012]); end
    tick();
  endtask

  task automatic test_halt();
    bit saw_halt = 0;
    drive(1, 1, 1, 16'h002C);
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 0, 0);
      checks++; if (imem_req && imem_addr > 16'h0032) begin errors++; $display("FAIL halt_overrun got addr %h exp none past 0032", imem_addr); end
      if (inst_valid && inst_pc == 16'h0032 && inst_data == HALT) saw_halt = 1;
      tick();
    end
    drive(1, 1, 0, 0);
    checks++; if (halted !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL halt_state got %b/%b exp 1/0", halted, imem_req); end
    checks++; if (!saw_halt) begin errors++; $display("FAIL halt_delivered got 0 exp 1"); end
    drive(1, 1, 1, 16'h0000);
    tick();
    drive(1, 1, 0, 0);
    checks++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL halt_restart got %b/%b/%h exp 0/1/0000", halted, imem_req, imem_addr); end
    tick();
  endtask

  task automatic test_wrap_and_reset();
    drive(1, 1, 1, 16'hFFFF);
    tick();
    drive(1, 1, 0, 0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'hFFFE) begin errors++; $display("FAIL wrap_top got %b/%h exp 1/FFFE", imem_req, imem_addr); end
    tick();
    drive(0, 1, 0, 0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %b/%h exp 1/0000", imem_req, imem_addr); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL midwait_reset got %b/%0d exp 0/0", imem_req, fifo_count); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive(1, 1, 0, 0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin errors++; $display("FAIL refetch got %b/%h exp 1/%h", imem_req, imem_addr, RESET_PC); end
    tick();
  endtask

  task automatic test_random();
    bit          rv;
    logic [15:0] rpc;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rv  = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 16'h0028 : 16'($urandom);
      drive(($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0), rv, rpc);
      checks++; if (imem_req !== exp_req || (exp_req && imem_addr !== m_pc)) begin errors++; $display("FAIL rnd_req cyc %0d got %b/%h exp %b/%h", i, imem_req, imem_addr, exp_req, m_pc); end
      checks++; if (inst_valid !== exp_valid || (exp_valid && {inst_pc, inst_data} !== exp_head)) begin errors++; $display("FAIL rnd_head cyc %0d got %b/%h/%h exp %b/%h", i, inst_valid, inst_pc, inst_data, exp_valid, exp_head); end
      checks++; if (fifo_count !== 3'(q.size()) || halted !== m_halted) begin errors++; $display("FAIL rnd_state cyc %0d got %0d/%b exp %0d/%b", i, fifo_count, halted, q.size(), m_halted); end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem[i] = 16'($urandom);
      if (mem[i] == HALT) mem[i] = HALT ^ 16'h0001;
    end
    mem[0] = 16'h012F;
    mem[1] = 16'h012E;
    mem[2] = 16'h034C;
    mem[16'h0019] = HALT;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_straight_line();
    test_backpressure();
    test_wait_state();
    test_redirect_full();
    test_halt();
    test_wrap_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Instruction-fetch controller that sequences the word-addressed instruction memory for the 16-bit CPU.
- Generates fetch addresses (PC stepping by 2) and runs a req/ack handshake to the memory.
- Buffers fetched words with their PCs in a small prefetch queue and presents them to decode with valid/ready.
- Handles branch/jump redirects (flush + refetch) and stops fetching after a HALT instruction.

Parameters:
DEPTH, 4, prefetch queue entries (power of 2, >=2)
RESET_PC, 16'h0000, first fetch address after reset
HALT_INST, 16'hEFFF, instruction word that stops fetching

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  16  fetch byte address, bit0 always 0
imem_ack  in  1  memory accepts request; imem_rdata valid this cycle
imem_rdata  in  16  instruction word returned with ack
inst_valid  out  1  queue head valid to decode
inst_data  out  16  head instruction word
inst_pc  out  16  head instruction address
inst_ready  in  1  decode accepts head this cycle
redirect_valid  in  1  branch/jump taken; flush and refetch
redirect_pc  in  16  new fetch address
halted  out  1  HALT_INST fetched, fetching stopped
fifo_count  out  log2(DEPTH)+1  current queue occupancy

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low. Everything else is synchronous to the rising edge of clk.
- Reset values:
  - fetch_pc = RESET_PC; queue empty; halted = 0.
  - imem_req, inst_valid, fifo_count = 0; inst_data, inst_pc = 0.
- Reset mid-transaction abandons any request immediately.
- imem_req is combinational:
  - imem_req = !halted && !redirect_valid && (count < DEPTH).
  - imem_addr = fetch_pc while imem_req = 1.
  - Address is held stable until ack.
  - Dropping imem_req cancels the memory transaction.
- Fetch completes on a cycle with imem_req && imem_ack:
  - {imem_rdata, fetch_pc} is written to the queue tail.
  - fetch_pc <= fetch_pc + 2, wrapping 16'hFFFE -> 16'h0000.
  - Ack with imem_req = 0 is ignored.
- Zero-wait memory (ack tied 1) sustains one fetch per cycle when decode drains every cycle.
- Queue:
  - Circular FIFO, registered storage.
  - inst_valid = (count != 0); inst_data/inst_pc = head entry.
  - Dequeue on inst_valid && inst_ready.
  - Enqueue and dequeue in the same cycle leave count unchanged.
  - No bypass: a word fetched in cycle N is visible at the head no earlier than N+1.
  - Full: imem_req = 0. A dequeue in the full cycle re-enables the request the following cycle.
- HALT:
  - When the enqueued word equals HALT_INST, halted <= 1 and no further requests are made.
  - The HALT word itself is queued and delivered to decode normally.
  - Remaining queued words still drain.
- Redirect (redirect_valid = 1 in cycle N), highest priority:
  - imem_req = 0 in cycle N.
  - Any ack and any dequeue in cycle N are discarded.
  - At the end of N: queue flushed (count = 0), fetch_pc <= {redirect_pc[15:1], 1'b0}, halted <= 0.
  - Cycle N+1: inst_valid = 0 and imem_req issues the new address.
  - Back-to-back redirects: the last one wins.
- Arithmetic: pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits with range 0..DEPTH and never over- or underflows.

Test Plan:
- Reset + straight line: ack tied 1, memory words at 0x00/0x02/0x04 = 16'h012F/16'h012E/16'h034C, inst_ready = 1 -> inst_pc 0x0000, 0x0002, 0x0004 on consecutive cycles starting one cycle after reset release, with matching data.
- Backpressure: inst_ready = 0 for 10 cycles -> exactly DEPTH (4) fetches, imem_req = 0, fifo_count = 4. Raise ready -> entries drain in order, and fetch resumes at 0x0008 the cycle after the first dequeue.
- Wait-state memory: ack only every 3rd cycle -> imem_addr held stable across wait cycles, no duplicate or skipped PCs, queue content in order.
- Redirect with full queue and ack in the same cycle: redirect_pc = 16'h0025 -> acked word dropped, inst_valid = 0 next cycle, next imem_addr = 16'h0024, next inst_pc = 16'h0024.
- HALT: word 16'hEFFF at 0x0032 -> halted = 1 after its fetch, no req beyond 0x0032, HALT word delivered to decode. A later redirect to 0x0000 clears halted and fetch restarts.
- Wrap/reset: redirect to 16'hFFFE -> next fetch 0x0000. Assert rst_n = 0 mid-wait -> imem_req drops immediately, fifo_count = 0, refetch begins from RESET_PC.
